// File: rtl/score_display_mux.sv
// Dinosaur-game score keeper: 4-digit saturating BCD counter scanned onto a
// multiplexed 7-segment display, one digit per synchronised scan_clk rising edge.
module score_display_mux #(
    parameter int SYNC_STAGES   = 2,
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit SEG_ACT_LOW   = 1'b1
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic        run,
    input  logic        point,
    input  logic        clear_score,
    output logic [15:0] score_bcd,
    output logic        max_flag,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam logic [3:0] AN_OFF  = SEG_ACT_LOW ? 4'b1111 : 4'b0000;
    localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_BLANK_LOW = 7'b1111111;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick;
    logic [1:0]             idx;
    logic [1:0]             idx_next;
    logic [15:0]            score_next;
    logic                   carry;
    logic [3:0]             digit_sel;
    logic                   blank;
    logic [6:0]             seg_low_next;
    logic [3:0]             an_low_next;

    // Active-low pattern {g,f,e,d,c,b,a}; anything outside 0..9 is dark.
    function automatic logic [6:0] decode_low(input logic [3:0] nib);
        case (nib)
            4'd0:    decode_low = 7'b1000000;
            4'd1:    decode_low = 7'b1111001;
            4'd2:    decode_low = 7'b0100100;
            4'd3:    decode_low = 7'b0110000;
            4'd4:    decode_low = 7'b0011001;
            4'd5:    decode_low = 7'b0010010;
            4'd6:    decode_low = 7'b0000010;
            4'd7:    decode_low = 7'b1111000;
            4'd8:    decode_low = 7'b0000000;
            4'd9:    decode_low = 7'b0010000;
            default: decode_low = SEG_BLANK_LOW;
        endcase
    endfunction

    assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

    // NOTE: every register here uses non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // NOTE: each always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        score_next = score_bcd;
        carry      = 1'b0;
        if (clear_score) begin
            score_next = '0;
        end else if (point && run && !max_flag) begin
            carry = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (carry) begin
                    if (score_bcd[4*k +: 4] == 4'd9) begin
                        score_next[4*k +: 4] = 4'd0;
                    end else begin
                        score_next[4*k +: 4] = score_bcd[4*k +: 4] + 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            score_bcd <= '0;
            max_flag  <= 1'b0;
        end else begin
            score_bcd <= score_next;
            max_flag  <= (score_next == 16'h9999);
        end
    end

    // The display registers load the decode of the index being advanced to.
    assign idx_next  = idx + 2'd1;
    assign digit_sel = score_bcd[{idx_next, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        if (BLANK_LEADING) begin
            case (idx_next)
                2'd1:    blank = (score_bcd[15:4] == 12'h000);
                2'd2:    blank = (score_bcd[15:8] == 8'h00);
                2'd3:    blank = (score_bcd[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
        seg_low_next = blank ? SEG_BLANK_LOW : decode_low(digit_sel);
        an_low_next  = ~(4'b0001 << idx_next);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (tick) begin
            idx <= idx_next;
            an  <= SEG_ACT_LOW ? an_low_next : ~an_low_next;
            seg <= SEG_ACT_LOW ? seg_low_next : ~seg_low_next;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Randomised bench for score_display_mux: an integer-level score/display model
// is compared against the DUT every cycle, plus directed literal scenarios.
module tb_score_display_mux;

    localparam int S = 2;

    logic        clk;
    logic        rst;
    logic        scan_auto;
    logic        scan_gen;
    logic        scan_man;
    logic        scan_clk;
    logic        run;
    logic        point;
    logic        clear_score;
    logic [15:0] score_bcd;
    logic        max_flag;
    logic [3:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;

    assign scan_clk = scan_auto ? scan_gen : scan_man;

    score_display_mux #(.SYNC_STAGES(S), .BLANK_LEADING(1'b1), .SEG_ACT_LOW(1'b1)) dut (
        .clock_in(clk), .reset(rst), .scan_clk(scan_clk), .run(run), .point(point),
        .clear_score(clear_score), .score_bcd(score_bcd), .max_flag(max_flag),
        .an(an), .seg(seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: score as an integer, display digit k = (score / 10^k) % 10.
    function automatic logic [6:0] seg_of_digit(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int s, input int k);
        int pw;
        pw = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (k > 0 && s < pw) return 7'b1111111;
        return seg_of_digit((s / pw) % 10);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    int         m_score;
    int         m_idx;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic [7:0] hist;

    // hist[j] holds scan_clk as sampled j+1 edges ago; a rise seen S edges
    // back advances the display on this edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_score = 0;
            m_idx   = 0;
            m_an    = 4'b1111;
            m_seg   = 7'b1111111;
            hist    = '0;
        end else begin
            if (hist[S-1] && !hist[S]) begin
                m_idx = (m_idx + 1) % 4;
                m_an  = ~(4'b0001 << m_idx);
                m_seg = exp_seg(m_score, m_idx);
            end
            hist = {hist[6:0], scan_clk};
            if (clear_score) m_score = 0;
            else if (point && run && m_score < 9999) m_score = m_score + 1;
        end
    end

    always @(negedge clk) begin
        check("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
        check("max_flag", 32'(max_flag), 32'(m_score == 9999));
        check("an", 32'(an), 32'(m_an));
        check("seg", 32'(seg), 32'(m_seg));
    end

    int         adv_cnt = 0;
    logic [3:0] an_last = 4'b1111;
    always @(negedge clk) begin
        if (an !== an_last) adv_cnt++;
        an_last = an;
    end

    // Free-running scan clock with random half-periods.
    initial begin
        int cnt;
        scan_gen = 1'b0;
        cnt = 3;
        forever begin
            @(posedge clk);
            #2;
            if (cnt == 0) begin
                scan_gen = ~scan_gen;
                cnt = $urandom_range(3, 9);
            end else begin
                cnt--;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic add_points(input int n);
        point = 1'b1;
        step(n);
        point = 1'b0;
    endtask

    task automatic scan_pulse(input int hi, input int lo);
        scan_man = 1'b1;
        step(hi);
        scan_man = 1'b0;
        step(lo);
    endtask

    task automatic wait_an(input string name, input logic [3:0] target, input logic [6:0] exp_s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (an === target) begin
                found = 1'b1;
                check(name, 32'(seg), 32'(exp_s));
            end
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        logic [3:0] an_seq [4];
        an_seq[0] = 4'b1101; an_seq[1] = 4'b1011; an_seq[2] = 4'b0111; an_seq[3] = 4'b1110;

        rst = 1'b1; scan_auto = 1'b0; scan_man = 1'b0;
        run = 1'b0; point = 1'b0; clear_score = 1'b0;
        step(3);
        @(negedge clk);
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_seg", 32'(seg), 32'h0000007F);
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_max", 32'(max_flag), 32'h0);
        step(1);
        rst = 1'b0;
        step(4);

        // 10 scan edges at score 0000: single "0" on the ones digit only.
        for (int i = 0; i < 10; i++) begin
            scan_pulse(4, 4);
            @(negedge clk);
            check("scan_an", 32'(an), 32'(an_seq[i % 4]));
            check("scan_seg", 32'(seg), (i % 4 == 3) ? 32'h40 : 32'h7F);
        end

        // 123 points and its display.
        step(1);
        run = 1'b1;
        add_points(123);
        @(negedge clk);
        check("score_0123", 32'(score_bcd), 32'h0123);
        step(1);
        scan_auto = 1'b1;
        wait_an("d0_of_0123", 4'b1110, 7'b0110000);
        wait_an("d1_of_0123", 4'b1101, 7'b0100100);
        wait_an("d2_of_0123", 4'b1011, 7'b1111001);
        wait_an("d3_of_0123", 4'b0111, 7'b1111111);

        // Saturation at 9999.
        step(1);
        clear_score = 1'b1; step(1); clear_score = 1'b0;
        add_points(9999);
        @(negedge clk);
        check("score_9999", 32'(score_bcd), 32'h9999);
        check("max_set", 32'(max_flag), 32'h1);
        step(1);
        add_points(1);
        @(negedge clk);
        check("saturated", 32'(score_bcd), 32'h9999);
        step(1);
        clear_score = 1'b1; step(1); clear_score = 1'b0;
        @(negedge clk);
        check("clear_score", 32'(score_bcd), 32'h0);
        check("clear_max", 32'(max_flag), 32'h0);

        // Clear beats point; point ignored while not running.
        step(1);
        add_points(42);
        clear_score = 1'b1; point = 1'b1; step(1);
        clear_score = 1'b0; point = 1'b0;
        @(negedge clk);
        check("clear_over_point", 32'(score_bcd), 32'h0);
        step(1);
        add_points(5);
        run = 1'b0;
        add_points(1);
        run = 1'b1;
        @(negedge clk);
        check("point_not_running", 32'(score_bcd), 32'h0005);

        // scan_clk held high gives one advance; a 1-cycle glitch at most one.
        step(1);
        scan_auto = 1'b0; scan_man = 1'b0;
        step(12);
        base = adv_cnt;
        scan_pulse(1000, 10);
        @(negedge clk);
        check("held_high_one_tick", 32'(adv_cnt - base), 32'd1);
        step(1);
        base = adv_cnt;
        scan_pulse(1, 10);
        @(negedge clk);
        check("glitch_at_most_one", 32'(adv_cnt - base <= 1), 32'd1);

        // Random traffic under the free-running scan clock.
        step(1);
        scan_auto = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            run         = ($urandom_range(0, 9) != 0);
            point       = $urandom_range(0, 1);
            clear_score = ($urandom_range(0, 199) == 0);
            step(1);
        end
        run = 1'b1; point = 1'b0; clear_score = 1'b0;

        // Reset in the middle of a scan, then restart from idx 0.
        clear_score = 1'b1; step(1); clear_score = 1'b0;
        add_points(777);
        wait_an("d2_of_0777", 4'b1011, 7'b1111000);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_an", 32'(an), 32'h0000000F);
        check("midrst_seg", 32'(seg), 32'h0000007F);
        check("midrst_score", 32'(score_bcd), 32'h0);
        step(1);
        scan_auto = 1'b0; scan_man = 1'b0;
        step(4);
        rst = 1'b0;
        step(4);
        @(negedge clk);
        check("idle_after_rst", 32'(an), 32'h0000000F);
        step(1);
        scan_pulse(4, 4);
        @(negedge clk);
        check("first_tick_idx1", 32'(an), 32'(4'b1101));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
